// File: rtl/gt_writeback_buffer.sv
// -----------------------------------------------------------------------------
// gt_writeback_buffer
// Write-back buffer between the victim cache and main memory. Dirty lines
// evicted from the victim cache are queued in a small circular FIFO and
// drained one at a time to main memory over a valid/ack handshake. A pushed
// line that hits a queued, not-yet-in-flight entry is coalesced into it. A
// combinational lookup lets a victim-cache miss be served from a queued line.
//
// Ports:
//   CLK          clock, all state changes on posedge
//   RST          synchronous active-high reset
//   push_valid   evicted line presented by the victim cache
//   push_addr    byte address of the evicted line
//   push_data    evicted line data
//   push_ready   buffer accepts a push this cycle
//   lookup_addr  address probed on a victim-cache miss
//   lookup_hit   a buffered line matches lookup_addr
//   lookup_data  youngest matching line data, 0 when no hit
//   mem_wr_en    write request to main memory
//   mem_addr     line-aligned write address
//   mem_data     write data
//   mem_ack      memory accepted the current write
//   empty        nothing queued and the drain FSM is idle
// -----------------------------------------------------------------------------
module gt_writeback_buffer #(
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [LINE_W-1:0] push_data,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [LINE_W-1:0] lookup_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic              empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LINE_AW = ADDR_W - OFFSET_BITS;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } drainState_t;

    logic [LINE_AW-1:0] entryLine_r [DEPTH];
    logic [LINE_W-1:0]  entryData_r [DEPTH];
    logic [DEPTH-1:0]   entryValid_r;
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [PTR_W:0]     count_r;
    drainState_t        state_r;
    drainState_t        nextState_s;
    logic               memWrEn_r;
    logic [ADDR_W-1:0]  memAddr_r;
    logic [LINE_W-1:0]  memData_r;

    logic [LINE_AW-1:0] pushLine_s;
    logic [LINE_AW-1:0] lookupLine_s;
    logic               pushFire_s;
    logic               popFire_s;
    logic               allocFire_s;
    logic               coalHit_s;
    logic [PTR_W-1:0]   coalIdx_s;
    logic               lookHit_s;
    logic [PTR_W-1:0]   lookIdx_s;
    logic [LINE_W-1:0]  headLoadData_s;
    logic               unusedOffsetBits_s;

    // Offset bits only select a byte inside the line; they never take part in matching.
    assign unusedOffsetBits_s = ^{push_addr[OFFSET_BITS-1:0], lookup_addr[OFFSET_BITS-1:0]};

    assign pushLine_s   = push_addr[ADDR_W-1:OFFSET_BITS];
    assign lookupLine_s = lookup_addr[ADDR_W-1:OFFSET_BITS];
    assign push_ready   = !RST && (count_r < FULL_CNT);
    assign pushFire_s   = push_valid && push_ready;
    assign popFire_s    = (state_r == WRITE) && mem_ack;
    assign allocFire_s  = pushFire_s && !coalHit_s;
    assign empty        = (count_r == '0) && (state_r == IDLE);
    assign mem_wr_en    = memWrEn_r;
    assign mem_addr     = memAddr_r;
    assign mem_data     = memData_r;
    assign lookup_hit   = lookHit_s;
    assign lookup_data  = lookHit_s ? entryData_r[lookIdx_s] : '0;

    // Youngest-match search for coalescing and lookup: walk oldest to youngest, last hit wins.
    always_comb begin : matchSearch
        logic [PTR_W-1:0] idx;
        logic             coalMatch;
        logic             lookMatch;
        idx       = '0;
        coalMatch = 1'b0;
        lookMatch = 1'b0;
        coalHit_s = 1'b0;
        coalIdx_s = '0;
        lookHit_s = 1'b0;
        lookIdx_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx       = head_r + PTR_W'(k);
            // The in-flight head is frozen so the data on the memory bus stays stable.
            coalMatch = entryValid_r[idx] && (entryLine_r[idx] == pushLine_s) &&
                        !((state_r == WRITE) && (idx == head_r));
            lookMatch = entryValid_r[idx] && (entryLine_r[idx] == lookupLine_s);
            coalHit_s = coalHit_s | coalMatch;
            coalIdx_s = coalMatch ? idx : coalIdx_s;
            lookHit_s = lookHit_s | lookMatch;
            lookIdx_s = lookMatch ? idx : lookIdx_s;
        end
    end

    // Head data to launch; a same-edge coalesce onto the idle head is forwarded so it is not lost.
    always_comb begin
        if (pushFire_s && coalHit_s && (coalIdx_s == head_r)) begin
            headLoadData_s = push_data;
        end else begin
            headLoadData_s = entryData_r[head_r];
        end
    end

    // Drain FSM next-state logic.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (count_r != '0) begin
                    nextState_s = WRITE;
                end else begin
                    nextState_s = IDLE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = WRITE;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Control state: pointers, count, valid bits, FSM and the registered memory request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_r       <= '0;
            tail_r       <= '0;
            count_r      <= '0;
            entryValid_r <= '0;
            state_r      <= IDLE;
            memWrEn_r    <= 1'b0;
            memAddr_r    <= '0;
            memData_r    <= '0;
        end else begin
            state_r <= nextState_s;
            if ((state_r == IDLE) && (count_r != '0)) begin
                memWrEn_r <= 1'b1;
                memAddr_r <= {entryLine_r[head_r], {OFFSET_BITS{1'b0}}};
                memData_r <= headLoadData_s;
            end else if (popFire_s) begin
                memWrEn_r <= 1'b0;
            end
            // Allocation and pop never target the same slot: allocation needs a free slot, pop a full head.
            if (allocFire_s) begin
                entryValid_r[tail_r] <= 1'b1;
                tail_r               <= tail_r + PTR_W'(1);
            end
            if (popFire_s) begin
                entryValid_r[head_r] <= 1'b0;
                head_r               <= head_r + PTR_W'(1);
            end
            case ({allocFire_s, popFire_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload storage; validity is tracked separately, so no reset is needed here.
    always_ff @(posedge CLK) begin
        if (pushFire_s && !RST) begin
            if (coalHit_s) begin
                entryData_r[coalIdx_s] <= push_data;
            end else begin
                entryLine_r[tail_r] <= pushLine_s;
                entryData_r[tail_r] <= push_data;
            end
        end
    end

endmodule

// File: tb/tb_gt_writeback_buffer.sv
module tb_gt_writeback_buffer;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              CLK = 1'b0;
    logic              RST;
    logic              push_valid;
    logic [ADDR_W-1:0] push_addr;
    logic [LINE_W-1:0] push_data;
    logic              push_ready;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit;
    logic [LINE_W-1:0] lookup_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_data;
    logic              mem_ack;
    logic              empty;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    logic [LINE_W-1:0] dA, dB, dC, dD, dE;

    gt_writeback_buffer #(
        .DEPTH(4), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_BITS(5)
    ) dut (
        .CLK(CLK), .RST(RST),
        .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data),
        .push_ready(push_ready),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ack(mem_ack), .empty(empty)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: a write completes at the posedge following a negedge where wr_en and ack are both high.
    always @(negedge CLK) begin
        if (!RST && mem_wr_en && mem_ack) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL mem_write unexpected write addr=%h data=%h", mem_addr, mem_data);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (mem_addr !== e.addr || mem_data !== e.data) begin
                    errors++;
                    $display("FAIL mem_write got addr=%h data=%h expected addr=%h data=%h",
                             mem_addr, mem_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_line(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d, input bit expect_write);
        exp_t e;
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        if (expect_write) begin
            e.addr = a & 32'hFFFF_FFE0;
            e.data = d;
            expQ.push_back(e);
        end
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && !(empty === 1'b1 && expQ.size() == 0); i++) tick();
        checks++;
        if (!(empty === 1'b1 && expQ.size() == 0)) begin
            errors++;
            $display("FAIL %s drain: empty=%b pending=%0d required empty=1 pending=0", name, empty, expQ.size());
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0;
        lookup_addr = '0; mem_ack = 1'b0;
        tick(); tick();
        checks++;
        if (push_ready !== 1'b0) begin errors++; $display("FAIL reset_push_ready got %b required 0", push_ready); end
        RST = 1'b0;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0 || mem_addr !== '0 || mem_data !== '0) begin
            errors++; $display("FAIL reset_mem got wr_en=%b addr=%h required 0/0", mem_wr_en, mem_addr);
        end
        checks++;
        if (empty !== 1'b1 || push_ready !== 1'b1 || lookup_hit !== 1'b0) begin
            errors++; $display("FAIL reset_status got empty=%b ready=%b hit=%b required 1/1/0", empty, push_ready, lookup_hit);
        end
    endtask

    task automatic test_single();
        mem_ack = 1'b1;
        push_line(32'h0000_0040, {8{32'hAAAA_AAAA}}, 1'b1);
        checks++;
        if (mem_wr_en !== 1'b0 || empty !== 1'b0) begin
            errors++; $display("FAIL single_after_push got wr_en=%b empty=%b required 0/0", mem_wr_en, empty);
        end
        tick();
        checks++;
        if (mem_wr_en !== 1'b1 || mem_addr !== 32'h0000_0040 || mem_data !== {8{32'hAAAA_AAAA}}) begin
            errors++; $display("FAIL single_launch got wr_en=%b addr=%h required 1/00000040", mem_wr_en, mem_addr);
        end
        tick();
        checks++;
        if (mem_wr_en !== 1'b0 || empty !== 1'b1 || expQ.size() != 0) begin
            errors++; $display("FAIL single_pop got wr_en=%b empty=%b pending=%0d required 0/1/0", mem_wr_en, empty, expQ.size());
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_full();
        mem_ack = 1'b0;
        push_line(32'h0000_0000, dA, 1'b1);
        push_line(32'h0000_0020, dB, 1'b1);
        push_line(32'h0000_0040, dC, 1'b1);
        push_line(32'h0000_0060, dD, 1'b1);
        checks++;
        if (push_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b required 0", push_ready); end
        push_line(32'h0000_0080, dE, 1'b0);
        lookup_addr = 32'h0000_0045; #1;
        checks++;
        if (lookup_hit !== 1'b1 || lookup_data !== dC) begin
            errors++; $display("FAIL full_lookup_hit got hit=%b data=%h required 1/%h", lookup_hit, lookup_data, dC);
        end
        lookup_addr = 32'h0000_0080; #1;
        checks++;
        if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
            errors++; $display("FAIL full_lookup_miss got hit=%b data=%h required 0/0", lookup_hit, lookup_data);
        end
        mem_ack = 1'b1;
        wait_drain("full");
        mem_ack = 1'b0;
    endtask

    task automatic test_coalesce();
        exp_t e;
        mem_ack = 1'b0;
        push_line(32'h0000_0000, dD, 1'b1);
        tick();
        push_line(32'h0000_0100, dA, 1'b0);
        push_line(32'h0000_011F, dB, 1'b0);
        e.addr = 32'h0000_0100; e.data = dB; expQ.push_back(e);
        lookup_addr = 32'h0000_0100; #1;
        checks++;
        if (lookup_hit !== 1'b1 || lookup_data !== dB) begin
            errors++; $display("FAIL coalesce_lookup got hit=%b data=%h required 1/%h", lookup_hit, lookup_data, dB);
        end
        push_line(32'h0000_0300, dC, 1'b1);
        checks++;
        if (push_ready !== 1'b1) begin errors++; $display("FAIL coalesce_count3_ready got %b required 1", push_ready); end
        push_line(32'h0000_0320, dE, 1'b1);
        checks++;
        if (push_ready !== 1'b0) begin errors++; $display("FAIL coalesce_count4_ready got %b required 0", push_ready); end
        mem_ack = 1'b1;
        wait_drain("coalesce");
        mem_ack = 1'b0;
    endtask

    task automatic test_inflight();
        mem_ack = 1'b0;
        push_line(32'h0000_0200, dA, 1'b1);
        tick();
        push_line(32'h0000_0200, dB, 1'b1);
        lookup_addr = 32'h0000_0200; #1;
        checks++;
        if (lookup_data !== dB || mem_data !== dA) begin
            errors++; $display("FAIL inflight_stable got lookup=%h mem=%h required %h/%h", lookup_data, mem_data, dB, dA);
        end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        checks++;
        if (lookup_hit !== 1'b1 || lookup_data !== dB) begin
            errors++; $display("FAIL inflight_after_pop1 got hit=%b data=%h required 1/%h", lookup_hit, lookup_data, dB);
        end
        tick();
        checks++;
        if (mem_wr_en !== 1'b1 || mem_data !== dB) begin
            errors++; $display("FAIL inflight_second got wr_en=%b data=%h required 1/%h", mem_wr_en, mem_data, dB);
        end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        checks++;
        if (lookup_hit !== 1'b0 || empty !== 1'b1 || expQ.size() != 0) begin
            errors++; $display("FAIL inflight_done got hit=%b empty=%b pending=%0d required 0/1/0", lookup_hit, empty, expQ.size());
        end
    endtask

    task automatic test_full_pop_push();
        mem_ack = 1'b0;
        push_line(32'h0000_0400, dA, 1'b1);
        push_line(32'h0000_0420, dB, 1'b1);
        push_line(32'h0000_0440, dC, 1'b1);
        push_line(32'h0000_0460, dD, 1'b1);
        mem_ack = 1'b1;
        push_line(32'h0000_0480, dE, 1'b0);
        mem_ack = 1'b0;
        lookup_addr = 32'h0000_0480; #1;
        checks++;
        if (push_ready !== 1'b1 || lookup_hit !== 1'b0) begin
            errors++; $display("FAIL fullpop_reject got ready=%b hit=%b required 1/0", push_ready, lookup_hit);
        end
        push_line(32'h0000_04A0, dE, 1'b1);
        checks++;
        if (push_ready !== 1'b0) begin errors++; $display("FAIL fullpop_count3 got ready=%b required 0", push_ready); end
        mem_ack = 1'b1;
        wait_drain("fullpop");
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_midwrite();
        mem_ack = 1'b0;
        push_line(32'h0000_0600, dA, 1'b1);
        push_line(32'h0000_0620, dB, 1'b1);
        RST = 1'b1; mem_ack = 1'b1;
        tick();
        RST = 1'b0; mem_ack = 1'b0;
        expQ.delete();
        lookup_addr = 32'h0000_0600; #1;
        checks++;
        if (mem_wr_en !== 1'b0 || empty !== 1'b1 || push_ready !== 1'b1 || lookup_hit !== 1'b0) begin
            errors++; $display("FAIL midreset got wr_en=%b empty=%b ready=%b hit=%b required 0/1/1/0",
                               mem_wr_en, empty, push_ready, lookup_hit);
        end
        mem_ack = 1'b1;
        push_line(32'h0000_0700, dC, 1'b1);
        wait_drain("midreset");
        mem_ack = 1'b0;
    endtask

    initial begin
        dA = {8{32'h1111_0A0A}};
        dB = {8{32'h2222_0B0B}};
        dC = {8{32'h3333_0C0C}};
        dD = {8{32'h4444_0D0D}};
        dE = {8{32'h5555_0E0E}};
        test_reset();
        test_single();
        test_full();
        test_coalesce();
        test_inflight();
        test_full_pop_push();
        test_reset_midwrite();
        checks++;
        if (expQ.size() != 0) begin errors++; $display("FAIL leftover_writes got %0d required 0", expQ.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gt_writeback_buffer.md
Name: gt_writeback_buffer

Overview:
- Write-back buffer directly downstream of GT_victim.
- Accepts dirty 256-bit lines evicted from the victim cache, queues up to DEPTH of them and drains them one at a time to GT_main_memory over a valid/ack write handshake.
- Provides a combinational line lookup so a victim-cache miss can be serviced from a line still waiting in the buffer, avoiding a stale main-memory read.

Parameters:
DEPTH, 4, number of line entries; power of 2, >= 2
ADDR_W, 32, byte address width
LINE_W, 256, line data width (32-byte line)
OFFSET_BITS, 5, byte-offset bits ignored for line matching

Ports:
CLK  in  1  clock; all state changes on posedge
RST  in  1  synchronous, active-high reset
push_valid  in  1  victim cache presents an evicted line
push_addr  in  ADDR_W  byte address of the evicted line
push_data  in  LINE_W  evicted line data
push_ready  out  1  buffer can accept a push this cycle
lookup_addr  in  ADDR_W  address probed on a victim-cache miss
lookup_hit  out  1  a buffered line matches lookup_addr
lookup_data  out  LINE_W  data of the youngest matching entry; 0 when no hit
mem_wr_en  out  1  write request to main memory
mem_addr  out  ADDR_W  line-aligned write address, low OFFSET_BITS = 0
mem_data  out  LINE_W  write data
mem_ack  in  1  memory accepted the current write
empty  out  1  count==0 and drain FSM in IDLE

Behaviour:
- Reset (RST high at posedge):
  - count=0, head=tail=0, all entries invalid, FSM=IDLE.
  - mem_wr_en=0, mem_addr=0, mem_data=0.
  - push_ready is forced 0 while RST is high.
- Storage: circular FIFO of {line_addr = addr[ADDR_W-1:OFFSET_BITS], data}. Head and tail pointers wrap modulo DEPTH.
- push_ready = !RST && (count < DEPTH), computed from the registered count. A pop in the same cycle does not open a slot; a push while full is rejected even if mem_ack is high.
- Push accepted at a posedge when push_valid && push_ready:
  - Coalesce: if the push line matches a valid entry that is not the head currently in WRITE, overwrite that entry's data. Count and pointers are unchanged. If several entries match, the youngest is written.
  - Otherwise, allocate at tail: tail+1, count+1.
  - A push that matches only the in-flight head allocates a new entry, so the head write data stays stable.
- Drain FSM:
  - IDLE: if count>0 at posedge, load mem_addr={head line,OFFSET_BITS'b0} and mem_data=head data, set mem_wr_en=1, go to WRITE.
  - WRITE: mem_wr_en, mem_addr and mem_data hold stable. When mem_ack=1 at posedge: pop head (head+1, count-1), mem_wr_en=0, go to IDLE.
  - One bubble cycle separates consecutive writes.
  - mem_ack is ignored in IDLE.
- Latency: a push into an empty buffer at edge N gives mem_wr_en=1 after edge N+1.
- Simultaneous push and pop at the same edge: both take effect; count is unchanged. A coalesce onto a non-head entry during a pop is legal.
- Lookup:
  - Purely combinational over stored valid entries, including the in-flight head.
  - A push in the same cycle is not visible until after its edge.
  - Youngest match wins.
- empty = (count==0) && FSM==IDLE.
- Reset mid-WRITE: the write is abandoned. mem_wr_en=0 and empty=1 after the edge. An ack on that same edge is ignored.

Test Plan:
1. Reset, push 0x00000040 with data 0xAA..AA at edge N, mem_ack=1 -> mem_wr_en=1, mem_addr=0x40 and mem_data=0xAA..AA after edge N+1; popped at edge N+2; empty=1 afterward.
2. mem_ack held 0, push lines 0x000, 0x020, 0x040, 0x060 -> push_ready=0 after the 4th push; a 5th push of 0x080 is dropped; lookup 0x045 gives hit=1 with the data of 0x040; lookup 0x080 gives hit=0 and data=0.
3. While head 0x000 is in WRITE, push 0x100 data A, then push 0x11F data B -> count stays 2; lookup 0x100 returns B; memory later receives addr 0x100 with data B, exactly once.
4. Head 0x200 data A is in WRITE; push 0x200 data B -> new entry allocated; memory receives 0x200/A, then 0x200/B; lookup returns B until the second pop.
5. Full buffer, FSM in WRITE; mem_ack=1 and push_valid=1 on the same edge -> head popped, push rejected, count=3; push_ready=1 next cycle.
6. Assert RST for one cycle during WRITE with mem_ack=1 -> mem_wr_en=0, empty=1, count=0 after the edge; the next push drains normally.
